// File: rtl/fpa_setup_pkg.sv
// Shared types and helpers for the floating-point adder serial setup path.
// Frame-bit placement lives here so the loader and any future users agree on it.
package fpa_setup_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } setup_state_t;

    // Destination bit inside the frame word for the k-th received serial bit.
    function automatic int unsigned bit_index(
        input int unsigned k,
        input bit          msb_first,
        input int unsigned width
    );
        return msb_first ? (width - 1 - k) : k;
    endfunction

endpackage

// File: rtl/setup_out_buf.sv
// Output word register: takes a one-cycle load pulse, publishes with valid/ready, flags overrun.
// Zero-cycle load-to-output beyond the register; a load while a word is pending and not accepted is dropped.
module setup_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] word_in,
    input  logic             ready_in,
    input  logic             abort_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid_out,
    output logic             overrun_out
);

    logic [WIDTH-1:0] par_q, par_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        par_d = par_q;
        vld_d = vld_q;
        ovr_d = ovr_q;

        if (vld_q && ready_in) begin
            vld_d = 1'b0;
        end

        // A completion in the same cycle as the consumer's accept replaces the word seamlessly.
        if (load_in) begin
            if (!vld_q || ready_in) begin
                par_d = word_in;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (abort_in) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            par_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            par_q <= par_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign parallel_out = par_q;
    assign valid_out    = vld_q;
    assign overrun_out  = ovr_q;

endmodule

// File: rtl/setup_loader.sv
// Serial-to-parallel setup loader: shifts WIDTH bits into staging, publishes on the final-bit edge.
// Word visible right after the final-bit edge; a completed frame is dropped (overrun) if the previous word is unaccepted.
module setup_loader
    import fpa_setup_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             serial_in,
    input  logic             abort_in,
    input  logic             ready_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             overrun_out
);

    setup_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [CNT_W-1:0] dst_idx;
    logic             load;

    assign dst_idx = CNT_W'(bit_index(32'(cnt_q), MSB_FIRST != 0, WIDTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        load    = 1'b0;

        if (abort_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (en_in) begin
            stage_d[dst_idx] = serial_in;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                load    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    assign busy_out = (state_q == SHIFT);

    // stage_d already holds the final bit, so the word publishes on the same edge that samples it.
    setup_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .load_in      (load),
        .word_in      (stage_d),
        .ready_in     (ready_in),
        .abort_in     (abort_in),
        .parallel_out (parallel_out),
        .valid_out    (valid_out),
        .overrun_out  (overrun_out)
    );

endmodule
